// File: rtl/button_debounce_bank.sv
// button_debounce_bank: multi-channel push-button conditioner.
// Each channel synchronises its raw level, filters bounce with a stability counter,
// and emits registered press/release strobes plus long-press and auto-repeat strobes.
module button_debounce_bank #(
    parameter int unsigned NUM_BTN       = 5,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CNT    = 4,
    parameter int unsigned HOLD_CYCLES   = 10,
    parameter int unsigned REPEAT_EN     = 1,
    parameter int unsigned REPEAT_CYCLES = 3
) (
    input  logic               slow_clock,
    input  logic               resetn,
    input  logic [NUM_BTN-1:0] push_button,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] long_press,
    output logic [NUM_BTN-1:0] btn_repeat
);

    localparam int unsigned CNT_W  = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REPEAT_CYCLES - 1);
    localparam bit                RepOn    = (REPEAT_EN != 0);

    logic [NUM_BTN-1:0] sync_q [SYNC_STAGES];
    logic [NUM_BTN-1:0] sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Metastability synchroniser: plain shift chain, all channels in parallel
    always_ff @(posedge slow_clock or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= push_button;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic [REP_W-1:0]  rep_q, rep_d;
        logic              level_q, level_d;
        logic              press_q, press_d;
        logic              release_q, release_d;
        logic              long_q, long_d;
        logic              repeat_q, repeat_d;
        logic              differ, flip, held;

        // Stability filter, strobe generation and hold/repeat timing for one channel
        always_comb begin
            differ    = sync_out[i] ^ level_q;
            flip      = differ && (cnt_q == CNT_MAX);
            // A flipping edge never counts as held, so release suppresses long/repeat
            held      = level_q && !flip;
            level_d   = flip ? sync_out[i] : level_q;
            cnt_d     = (differ && !flip) ? cnt_q + CNT_W'(1) : '0;
            press_d   = flip && !level_q;
            release_d = flip && level_q;
            hold_d    = '0;
            rep_d     = '0;
            long_d    = 1'b0;
            repeat_d  = 1'b0;
            if (held) begin
                if (hold_q == HOLD_MAX) begin
                    hold_d = hold_q;
                    if (RepOn) begin
                        if (rep_q == REP_MAX) begin
                            repeat_d = 1'b1;
                        end else begin
                            rep_d = rep_q + REP_W'(1);
                        end
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                    long_d = (hold_q == HOLD_PRE);
                end
            end
        end

        // Channel state and registered outputs
        always_ff @(posedge slow_clock or negedge resetn) begin
            if (!resetn) begin
                cnt_q     <= '0;
                hold_q    <= '0;
                rep_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                hold_q    <= hold_d;
                rep_q     <= rep_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
                repeat_q  <= repeat_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign long_press[i]  = long_q;
        assign btn_repeat[i]  = RepOn ? repeat_q : 1'b0;
    end

endmodule

// File: tb/tb_button_debounce_bank.sv
// Bench for button_debounce_bank: a window/age-based model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_button_debounce_bank;

    localparam int NB = 5;
    localparam int SS = 2;
    localparam int SC = 4;
    localparam int HC = 10;
    localparam int RC = 3;

    logic          slow_clock  = 1'b0;
    logic          resetn      = 1'b1;
    logic [NB-1:0] push_button = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release, long_press, btn_repeat;
    logic [NB-1:0] nr_level, nr_press, nr_release, nr_long, nr_repeat;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 slow_clock = ~slow_clock;

    button_debounce_bank #(
        .NUM_BTN(NB), .SYNC_STAGES(SS), .STABLE_CNT(SC),
        .HOLD_CYCLES(HC), .REPEAT_EN(1), .REPEAT_CYCLES(RC)
    ) dut (
        .slow_clock (slow_clock),
        .resetn     (resetn),
        .push_button(push_button),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .long_press (long_press),
        .btn_repeat (btn_repeat)
    );

    button_debounce_bank #(
        .NUM_BTN(NB), .SYNC_STAGES(SS), .STABLE_CNT(SC),
        .HOLD_CYCLES(HC), .REPEAT_EN(0), .REPEAT_CYCLES(RC)
    ) dut_nr (
        .slow_clock (slow_clock),
        .resetn     (resetn),
        .push_button(push_button),
        .btn_level  (nr_level),
        .btn_press  (nr_press),
        .btn_release(nr_release),
        .long_press (nr_long),
        .btn_repeat (nr_repeat)
    );

    task automatic cmp(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Level flips when the last SC synchronised samples all disagree with it; the
    // synchronised sample at an edge is the raw input sampled SS edges earlier.
    // Long/repeat strobes follow from the age (edges) since the rising flip.
    logic [NB-1:0] raw_h [SS];
    logic [NB-1:0] syn_h [SC];
    logic [NB-1:0] m_level, m_press, m_release, m_long, m_rep;
    int            m_cyc;
    int            rise_t [NB];
    logic [NB-1:0] s_now, nl, np, nr, nlg, nrp;
    int            age;
    bit            all_diff;

    always @(posedge slow_clock or negedge resetn) begin
        if (!resetn) begin
            for (int j = 0; j < SS; j++) raw_h[j] <= '0;
            for (int j = 0; j < SC; j++) syn_h[j] <= '0;
            for (int c = 0; c < NB; c++) rise_t[c] <= 0;
            m_level   <= '0;
            m_press   <= '0;
            m_release <= '0;
            m_long    <= '0;
            m_rep     <= '0;
            m_cyc     <= 0;
        end else begin
            s_now = raw_h[SS-1];
            for (int c = 0; c < NB; c++) begin
                all_diff = (s_now[c] != m_level[c]);
                for (int j = 0; j < SC - 1; j++) begin
                    if (syn_h[j][c] == m_level[c]) all_diff = 1'b0;
                end
                age    = m_cyc - rise_t[c];
                nl[c]  = all_diff ? ~m_level[c] : m_level[c];
                np[c]  = all_diff && !m_level[c];
                nr[c]  = all_diff && m_level[c];
                nlg[c] = !all_diff && m_level[c] && (age == HC);
                nrp[c] = !all_diff && m_level[c] && (age > HC) && ((age - HC) % RC == 0);
                if (np[c]) rise_t[c] <= m_cyc;
            end
            raw_h[0] <= push_button;
            for (int j = 1; j < SS; j++) raw_h[j] <= raw_h[j-1];
            syn_h[0] <= s_now;
            for (int j = 1; j < SC; j++) syn_h[j] <= syn_h[j-1];
            m_level   <= nl;
            m_press   <= np;
            m_release <= nr;
            m_long    <= nlg;
            m_rep     <= nrp;
            m_cyc     <= m_cyc + 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge slow_clock) begin
        if (chk_on) begin
            cmp("m_level", btn_level, m_level);
            cmp("m_press", btn_press, m_press);
            cmp("m_release", btn_release, m_release);
            cmp("m_long", long_press, m_long);
            cmp("m_repeat", btn_repeat, m_rep);
            cmp("m_nr_level", nr_level, m_level);
            cmp("m_nr_press", nr_press, m_press);
            cmp("m_nr_release", nr_release, m_release);
            cmp("m_nr_long", nr_long, m_long);
            cmp("m_nr_repeat", nr_repeat, '0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge slow_clock);
        #1;
    endtask

    task automatic settle();
        push_button = '0;
        repeat (12) step();
    endtask

    // Input already applied; first sampling edge is edge 0, press expected after edge 5
    task automatic qualify(input logic [NB-1:0] m);
        for (int k = 0; k < 5; k++) begin
            step();
            cmp("qual_wait", btn_press & m, '0);
        end
        step();
        cmp("qual_press", btn_press & m, m);
        cmp("qual_level", btn_level & m, m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] m;
        bit            pat [6];

        #3 resetn = 1'b0;
        chk_on = 1'b1;
        repeat (3) step();
        cmp("reset_level", btn_level, '0);
        cmp("reset_strobes", btn_press | btn_release | long_press | btn_repeat, '0);
        resetn = 1'b1;

        // Single press on ch0
        push_button = 5'b00001;
        qualify(5'b00001);
        cmp("s1_only_ch0", btn_level, 5'b00001);
        cmp("s1_press_vec", btn_press, 5'b00001);
        step();
        cmp("s1_press_one_cycle", btn_press, '0);
        settle();

        // Bounce on ch1: 1,1,0,1,1,0 never gives SC stable samples
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            push_button = {3'b000, pat[i], 1'b0};
            step();
            cmp("s2_bounce", (btn_level | btn_press | btn_release) & 5'b00010, '0);
        end
        push_button = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            cmp("s2_bounce_tail", (btn_level | btn_press | btn_release) & 5'b00010, '0);
        end

        // Long hold on ch2 with repeats, release sampled at press+26
        m = 5'b00100;
        push_button = m;
        qualify(m);
        for (int off = 1; off <= 40; off++) begin
            if (off == 26) push_button = '0;
            step();
            cmp("s3_long", long_press & m, (off == 10) ? m : '0);
            cmp("s3_repeat", btn_repeat & m,
                (off inside {13, 16, 19, 22, 25, 28}) ? m : '0);
            cmp("s3_release", btn_release & m, (off == 31) ? m : '0);
            cmp("s3_nr_long", nr_long & m, (off == 10) ? m : '0);
            cmp("s3_nr_repeat", nr_repeat, '0);
        end
        settle();

        // Short press on ch3: 6 debounced cycles, no long press
        m = 5'b01000;
        push_button = m;
        qualify(m);
        push_button = '0;
        for (int off = 1; off <= 12; off++) begin
            step();
            cmp("s4_release", btn_release & m, (off == 6) ? m : '0);
            cmp("s4_level", btn_level & m, (off < 6) ? m : '0);
            cmp("s4_long", long_press & m, '0);
        end
        settle();

        // ch0 and ch4 together, ch4 drops after 3 samples
        push_button = 5'b10001;
        repeat (3) step();
        push_button = 5'b00001;
        step();
        step();
        cmp("s5_not_yet", btn_level, '0);
        step();
        cmp("s5_level", btn_level, 5'b00001);
        cmp("s5_press", btn_press, 5'b00001);
        for (int i = 0; i < 6; i++) begin
            step();
            cmp("s5_ch4_quiet", (btn_level | btn_press) & 5'b10000, '0);
        end
        settle();

        // Reset mid-hold on ch2 at hold count 7, then requalify
        m = 5'b00100;
        push_button = m;
        qualify(m);
        repeat (7) step();
        cmp("s6_held", btn_level, m);
        resetn = 1'b0;
        #1;
        cmp("s6_rst_level", btn_level, '0);
        cmp("s6_rst_strobes", btn_press | btn_release | long_press | btn_repeat, '0);
        cmp("s6_rst_nr_level", nr_level, '0);
        step();
        resetn = 1'b1;
        qualify(m);
        for (int off = 1; off <= 12; off++) begin
            step();
            cmp("s6_long", long_press & m, (off == 10) ? m : '0);
        end
        settle();

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_debounce_bank.md
Name: button_debounce_bank

Overview:
- Parametrised multi-channel push-button conditioner. It generalises the single sampling flop used for the Basys3 push buttons.
- Each channel has a metastability synchroniser, a counter-based stability filter, and one-cycle press/release strobes.
- It also generates a long-press strobe and optional auto-repeat strobes.
- It sits between the raw board buttons and the sound/display mode FSMs, which consume only the clean strobes.

Parameters:
- NUM_BTN, 5, number of independent button channels (≥1).
- SYNC_STAGES, 2, synchroniser flop depth per channel (≥2).
- STABLE_CNT, 4, consecutive synchronised samples that must disagree with the debounced state before it flips (≥1).
- HOLD_CYCLES, 10, cycles a debounced press must last before long_press fires (≥2).
- REPEAT_EN, 1, 1 enables auto-repeat strobes after long_press; 0 disables them.
- REPEAT_CYCLES, 3, interval between repeat strobes (≥1).

Ports:
- slow_clock  input  1  sampling clock (the slowed debounce clock).
- resetn  input  1  asynchronous active-low reset.
- push_button  input  NUM_BTN  raw asynchronous button levels, 1 = pressed.
- btn_level  output  NUM_BTN  debounced level per channel.
- btn_press  output  NUM_BTN  one-cycle strobe on debounced 0→1.
- btn_release  output  NUM_BTN  one-cycle strobe on debounced 1→0.
- long_press  output  NUM_BTN  one-cycle strobe when a press reaches HOLD_CYCLES.
- btn_repeat  output  NUM_BTN  one-cycle auto-repeat strobes while held past long_press.

Behaviour:
- Clocking and reset: one clock, slow_clock. Reset is asynchronous and active-low (resetn).
- While resetn=0:
  - all synchroniser flops, stability counters, hold counters and repeat counters are 0;
  - all outputs are 0.
- Deassertion is not resynchronised here; it is done upstream.
- All outputs are registered. There are no combinational paths from push_button. Channels are fully independent.

Synchroniser:
- Chain of SYNC_STAGES flops per channel. sync[i] is the last stage.

Stability filter (per channel, evaluated every rising edge):
- sync==btn_level → cnt<=0.
- Otherwise, if cnt==STABLE_CNT-1 → btn_level<=sync and cnt<=0.
- Otherwise → cnt<=cnt+1.
- cnt width is clog2(STABLE_CNT) (minimum 1 bit). cnt never exceeds STABLE_CNT-1.
- Latency: let edge k be the first edge at which push_button is sampled at the new value, with the value held thereafter. btn_level changes at edge k+SYNC_STAGES+STABLE_CNT-1.
- A glitch shorter than STABLE_CNT synchronised samples never changes btn_level. It also restarts filtering: cnt clears as soon as sync returns to btn_level.

Strobes:
- btn_press / btn_release go high for exactly the one cycle following the edge at which btn_level flips 0→1 / 1→0. They are never both high on a channel.

Hold/repeat (per channel):
- hold_cnt clears on any edge where btn_level is 0 or is flipping. It increments while btn_level=1 and saturates at HOLD_CYCLES.
- long_press pulses for one cycle on the edge where hold_cnt goes HOLD_CYCLES-1→HOLD_CYCLES. That is HOLD_CYCLES cycles after btn_press.
- If REPEAT_EN=1:
  - rep_cnt starts at 0 on that edge and counts while held.
  - btn_repeat pulses each time rep_cnt wraps from REPEAT_CYCLES-1 to 0.
  - The first repeat strobe therefore comes REPEAT_CYCLES cycles after long_press, then one every REPEAT_CYCLES cycles.
- If REPEAT_EN=0: btn_repeat is tied to 0.
- Release (btn_level 1→0) clears hold_cnt and rep_cnt on the same edge. No long_press or btn_repeat strobe coincides with btn_release.
- A release before HOLD_CYCLES produces no long_press.

Reset mid-operation:
- Reset during a press, or with strobes high, immediately clears all outputs and counters.
- If the button is still pressed after reset, it is re-qualified from scratch: full SYNC_STAGES+STABLE_CNT latency, and a fresh btn_press.

Test Plan:
- Reset, then push_button=5'b00001 held from edge 0 → btn_level[0]=1 at edge 5, btn_press[0] high for exactly that cycle; other channels stay 0.
- Bounce ch1: high 2 cycles, low 1, high 2, low (never 4 stable) → btn_level[1], btn_press[1] and btn_release[1] remain 0 throughout.
- Hold ch2 pressed 30 cycles after btn_level rises → long_press[2] 10 cycles after btn_press[2]; btn_repeat[2] at +13, +16, +19 …; release → btn_release[2], no further repeats.
- Press ch3 for 6 debounced cycles, then release → btn_press then btn_release[3]; long_press[3] never fires.
- Channels 0 and 4 pressed on the same edge, ch4 released 3 cycles later (glitch) → ch0 qualifies at edge 5; ch4 never asserts.
- resetn pulsed low for 1 cycle during a held ch2 press at hold_cnt=7 → all outputs 0 immediately; btn_press[2] reappears 5 edges after resetn release; long_press[2] comes 10 cycles after that.
- REPEAT_EN=0 rerun of the hold scenario → long_press fires, btn_repeat stays 0.
